// File: rtl/counter_sweep_ctrl.sv
// Drives an 8-bit up/down counter through lo->hi->lo triangle sweeps for a programmed repetition count.
// Commands are accepted only in IDLE; abort returns to IDLE on the next edge.
module counter_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_enable,
  output logic             cnt_up_down,
  output logic             cnt_preload,
  output logic [WIDTH-1:0] cnt_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] sweeps_left
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] VAL_ONE = WIDTH'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [REP_W-1:0] reps_q, reps_d, sweeps_q, sweeps_d;
  logic             en_q, en_d, ud_q, ud_d, pre_q, pre_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      reps_q   <= '0;
      sweeps_q <= '0;
      en_q     <= 1'b0;
      ud_q     <= 1'b0;
      pre_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      reps_q   <= reps_d;
      sweeps_q <= sweeps_d;
      en_q     <= en_d;
      ud_q     <= ud_d;
      pre_q    <= pre_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    reps_d   = reps_q;
    sweeps_d = sweeps_q;
    en_d     = en_q;
    ud_d     = ud_q;
    pre_d    = pre_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        en_d  = 1'b0;
        pre_d = 1'b0;
        if (cmd_valid) begin
          if (cmd_lo < cmd_hi) begin
            lo_d     = cmd_lo;
            hi_d     = cmd_hi;
            reps_d   = cmd_reps;
            sweeps_d = cmd_reps;
            pre_d    = 1'b1;
            en_d     = 1'b1;
            state_d  = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        pre_d   = 1'b0;
        ud_d    = 1'b1;
        en_d    = 1'b1;
        state_d = S_UP;
      end
      // Turn one step early: the counter lands on the bound on the same edge.
      S_UP: begin
        if (count >= hi_q - VAL_ONE) begin
          ud_d    = 1'b0;
          state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (count <= lo_q + VAL_ONE) begin
          if (reps_q == '0) begin
            ud_d    = 1'b1;
            state_d = S_UP;
          end else if (sweeps_q == REP_ONE) begin
            en_d     = 1'b0;
            sweeps_d = '0;
            state_d  = S_DONE;
          end else begin
            sweeps_d = sweeps_q - REP_ONE;
            ud_d     = 1'b1;
            state_d  = S_UP;
          end
        end
      end
      S_DONE: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q == S_LOAD || state_q == S_UP || state_q == S_DOWN)) begin
      en_d     = 1'b0;
      pre_d    = 1'b0;
      sweeps_d = sweeps_q;
      state_d  = S_IDLE;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    cnt_enable  = en_q;
    cnt_up_down = ud_q;
    cnt_preload = pre_q;
    cnt_data    = lo_q;
    busy        = busy_q;
    done        = done_q;
    err         = err_q;
    sweeps_left = sweeps_q;
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench: a behavioural counter closes the loop; expected values are hand-derived per step.
module tb_counter_sweep_ctrl;

  logic       clk, reset, cmd_valid, cmd_ready, abort;
  logic [7:0] cmd_lo, cmd_hi, count, cnt_data;
  logic [3:0] cmd_reps, sweeps_left;
  logic       cnt_enable, cnt_up_down, cnt_preload, busy, done, err;
  logic       cnt_rst;

  int errors = 0;
  int checks = 0;
  int done_seen;

  int seq1[7] = '{3, 4, 5, 6, 5, 4, 3};
  int seq2[7] = '{12, 13, 12, 13, 12, 13, 12};
  int sl2[7]  = '{3, 3, 2, 2, 1, 1, 0};
  int seq5[5] = '{2, 3, 4, 3, 2};
  int seq6[5] = '{5, 6, 7, 6, 5};

  counter_sweep_ctrl #(.WIDTH(8), .REP_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_reps(cmd_reps), .abort(abort),
    .count(count), .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down),
    .cnt_preload(cnt_preload), .cnt_data(cnt_data), .busy(busy), .done(done),
    .err(err), .sweeps_left(sweeps_left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Attached counter: preload wins over counting; own reset only at start.
  always @(posedge clk) begin
    if (cnt_rst) count <= 8'd0;
    else if (cnt_preload) count <= cnt_data;
    else if (cnt_enable) count <= cnt_up_down ? count + 8'd1 : count - 8'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input int lo, input int hi, input int reps);
    cmd_lo    = 8'(lo);
    cmd_hi    = 8'(hi);
    cmd_reps  = 4'(reps);
    cmd_valid = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, int'(cmd_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_enable"}, int'(cnt_enable), 0);
    check({tag, "_preload"}, int'(cnt_preload), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    reset = 1'b1; cnt_rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_lo = 8'd0; cmd_hi = 8'd0; cmd_reps = 4'd0;
    tick(); tick();
    check_idle_outputs("rst");
    check("rst_updown", int'(cnt_up_down), 0);
    check("rst_data", int'(cnt_data), 0);
    check("rst_sweeps", int'(sweeps_left), 0);
    reset = 1'b0; cnt_rst = 1'b0;
    tick();
    check("rst_count", int'(count), 0);

    // lo=3 hi=6 reps=1
    send(3, 6, 1);
    tick();
    cmd_valid = 1'b0;
    check("t1_load_pre", int'(cnt_preload), 1);
    check("t1_load_en", int'(cnt_enable), 1);
    check("t1_load_busy", int'(busy), 1);
    check("t1_load_ready", int'(cmd_ready), 0);
    check("t1_load_data", int'(cnt_data), 3);
    check("t1_load_sweeps", int'(sweeps_left), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("t1_count%0d", i), int'(count), seq1[i]);
      check($sformatf("t1_done%0d", i), int'(done), (i == 6) ? 1 : 0);
    end
    check("t1_done_en", int'(cnt_enable), 0);
    check("t1_done_busy", int'(busy), 1);
    check("t1_done_sweeps", int'(sweeps_left), 0);
    tick();
    check_idle_outputs("t1_end");
    check("t1_end_count", int'(count), 3);

    // lo=12 hi=13 reps=3: turnaround every edge
    send(12, 13, 3);
    tick();
    cmd_valid = 1'b0;
    check("t2_load_sweeps", int'(sweeps_left), 3);
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("t2_count%0d", i), int'(count), seq2[i]);
      check($sformatf("t2_sweeps%0d", i), int'(sweeps_left), sl2[i]);
      if (done) done_seen++;
    end
    check("t2_done_now", int'(done), 1);
    tick();
    if (done) done_seen++;
    check("t2_done_count", done_seen, 1);
    check("t2_ready", int'(cmd_ready), 1);

    // rejected commands
    send(9, 9, 1);
    tick();
    cmd_valid = 1'b0;
    check("t3a_err", int'(err), 1);
    check("t3a_busy", int'(busy), 0);
    check("t3a_data", int'(cnt_data), 12);
    check("t3a_en", int'(cnt_enable), 0);
    tick();
    check("t3a_err_clr", int'(err), 0);
    send(20, 5, 2);
    tick();
    cmd_valid = 1'b0;
    check("t3b_err", int'(err), 1);
    check("t3b_busy", int'(busy), 0);
    check("t3b_data", int'(cnt_data), 12);
    check("t3b_sweeps", int'(sweeps_left), 0);
    tick();
    check("t3b_err_clr", int'(err), 0);
    check("t3b_count", int'(count), 12);

    // lo=0 hi=255 reps=0: endless sweep, abort after 600 cycles
    send(0, 255, 0);
    tick();
    cmd_valid = 1'b0;
    done_seen = 0;
    for (int j = 1; j <= 600; j++) begin
      int p;
      tick();
      p = (j - 1) % 510;
      check($sformatf("t4_count%0d", j), int'(count), (p <= 255) ? p : 510 - p);
      if (done) done_seen++;
    end
    check("t4_no_done", done_seen, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("t4_abort");
    check("t4_abort_sweeps", int'(sweeps_left), 0);
    check("t4_abort_count", int'(count), 90);
    tick();
    check("t4_stopped", int'(count), 90);

    // async reset in the middle of the down leg
    send(10, 20, 1);
    tick();
    cmd_valid = 1'b0;
    repeat (13) tick();
    check("t5_mid_count", int'(count), 18);
    check("t5_mid_dir", int'(cnt_up_down), 0);
    reset = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    check("t5_rst_updown", int'(cnt_up_down), 0);
    check("t5_rst_data", int'(cnt_data), 0);
    check("t5_rst_sweeps", int'(sweeps_left), 1 - 1);
    tick();
    check("t5_frozen", int'(count), 18);
    reset = 1'b0;
    send(2, 4, 1);
    tick();
    cmd_valid = 1'b0;
    check("t5_load_pre", int'(cnt_preload), 1);
    check("t5_load_data", int'(cnt_data), 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_count%0d", i), int'(count), seq5[i]);
      check($sformatf("t5_done%0d", i), int'(done), (i == 4) ? 1 : 0);
    end
    tick();
    check("t5_ready", int'(cmd_ready), 1);

    // command held valid while busy is taken only once back in IDLE
    send(5, 7, 1);
    tick();
    send(30, 40, 2);
    check("t6_load_data", int'(cnt_data), 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_count%0d", i), int'(count), seq6[i]);
      check($sformatf("t6_data%0d", i), int'(cnt_data), 5);
    end
    check("t6_done", int'(done), 1);
    tick();
    check("t6_idle_ready", int'(cmd_ready), 1);
    check("t6_idle_busy", int'(busy), 0);
    check("t6_idle_data", int'(cnt_data), 5);
    tick();
    cmd_valid = 1'b0;
    check("t6_acc_pre", int'(cnt_preload), 1);
    check("t6_acc_data", int'(cnt_data), 30);
    check("t6_acc_sweeps", int'(sweeps_left), 2);
    check("t6_acc_ready", int'(cmd_ready), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_busy", int'(busy), 0);
    check("t6_abort_ready", int'(cmd_ready), 1);
    check("t6_abort_sweeps", int'(sweeps_left), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
